// File: rtl/approx_adder_pipe.sv
// Pipelined WIDTH-bit adder with a per-transaction Lower-part-OR approximate mode.
// Define APPROX_ADDER_ERR_EN to add the exact-reference error outputs err/err_cnt.
module approx_adder_pipe #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned APPROX_BITS = 4,
  parameter int unsigned STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef APPROX_ADDER_ERR_EN
  ,
  output logic signed [WIDTH+1:0] err,
  output logic [15:0]             err_cnt
`endif
);

  localparam int unsigned CW = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] AMASK = WIDTH'((64'(1) << APPROX_BITS) - 64'(1));
  localparam logic [WIDTH-1:0] LMASK =
    (APPROX_BITS == 0) ? '0 : WIDTH'(64'(1) << (APPROX_BITS - 1));

  // Resolves one CW-bit slice starting at bit 'base'. Approximate bits OR the
  // operands (bit 0 also ORs the incoming cin); only the top approximate bit
  // produces a carry, a[i]&b[i], into the exact upper part.
  function automatic logic [CW:0] add_chunk(
    input logic [WIDTH-1:0] a_v,
    input logic [WIDTH-1:0] b_v,
    input logic             c_v,
    input logic             apx,
    input int unsigned      base
  );
    logic [WIDTH-1:0] as, bs, am, lm;
    logic [CW-1:0]    s;
    logic             c;
    as = a_v >> base;
    bs = b_v >> base;
    am = AMASK >> base;
    lm = LMASK >> base;
    s  = '0;
    c  = c_v;
    for (int unsigned j = 0; j < CW; j++) begin
      if (apx && am[j]) begin
        s[j] = as[j] | bs[j] | c;
        c    = lm[j] & as[j] & bs[j];
      end else begin
        s[j] = as[j] ^ bs[j] ^ c;
        c    = (as[j] & bs[j]) | (c & (as[j] ^ bs[j]));
      end
    end
    return {c, s};
  endfunction

  logic [STAGES-1:0] load;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned BASE = k * CW;

    logic             v_in, c_in, m_in;
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             v_q, c_q, c_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW:0]      r;
`ifdef APPROX_ADDER_ERR_EN
    logic             ec_in, ec_q, ec_d;
    logic [WIDTH-1:0] es_in, es_q, es_d;
    logic [CW:0]      re;
`endif

    if (k == 0) begin : g_src
      assign v_in = in_valid;
      assign a_in = a;
      assign b_in = b;
      assign m_in = approx_en;
      assign s_in = '0;
      assign c_in = cin;
`ifdef APPROX_ADDER_ERR_EN
      assign es_in = '0;
      assign ec_in = cin;
`endif
    end else begin : g_src
      assign v_in = g_st[k-1].v_q;
      assign a_in = g_st[k-1].g_fwd.a_q;
      assign b_in = g_st[k-1].g_fwd.b_q;
      assign m_in = g_st[k-1].g_fwd.m_q;
      assign s_in = g_st[k-1].s_q;
      assign c_in = g_st[k-1].c_q;
`ifdef APPROX_ADDER_ERR_EN
      assign es_in = g_st[k-1].es_q;
      assign ec_in = g_st[k-1].ec_q;
`endif
    end

    // A stage loads when empty or when its occupant moves on this cycle.
    if (k == STAGES - 1) begin : g_ld
      assign load[k] = ~v_q | out_ready;
    end else begin : g_ld
      assign load[k] = ~v_q | load[k+1];
    end

    always_comb begin
      r   = add_chunk(a_in, b_in, c_in, m_in, BASE);
      s_d = s_in;
      s_d[BASE +: CW] = r[CW-1:0];
      c_d = r[CW];
`ifdef APPROX_ADDER_ERR_EN
      re   = add_chunk(a_in, b_in, ec_in, 1'b0, BASE);
      es_d = es_in;
      es_d[BASE +: CW] = re[CW-1:0];
      ec_d = re[CW];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
`ifdef APPROX_ADDER_ERR_EN
        es_q <= '0;
        ec_q <= 1'b0;
`endif
      end else if (load[k]) begin
        v_q <= v_in;
        if (v_in) begin
          s_q <= s_d;
          c_q <= c_d;
`ifdef APPROX_ADDER_ERR_EN
          es_q <= es_d;
          ec_q <= ec_d;
`endif
        end
      end
    end

    // Operands and mode only need to travel to stages that still compute.
    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q, b_q;
      logic             m_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          m_q <= 1'b0;
        end else if (load[k] && v_in) begin
          a_q <= a_in;
          b_q <= b_in;
          m_q <= m_in;
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;

`ifdef APPROX_ADDER_ERR_EN
  logic [15:0] err_cnt_q;

  assign err = $signed({1'b0, cout, sum})
             - $signed({1'b0, g_st[STAGES-1].ec_q, g_st[STAGES-1].es_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (out_valid && out_ready && (err != '0) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Directed bench for approx_adder_pipe (default parameters) with hand-computed results.
module tb_approx_adder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        approx_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
`ifdef APPROX_ADDER_ERR_EN
  logic signed [17:0] err;
  logic [15:0]        err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    int          e;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  approx_adder_pipe #(
    .WIDTH      (16),
    .APPROX_BITS(4),
    .STAGES     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef APPROX_ADDER_ERR_EN
    ,
    .err      (err),
    .err_cnt  (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'(0));
      end else begin
        mon_e = q.pop_front();
        check("sum", 32'(sum), 32'(mon_e.s));
        check("cout", 32'(cout), 32'(mon_e.c));
`ifdef APPROX_ADDER_ERR_EN
        check("err", 32'(err), 32'(mon_e.e));
`endif
      end
    end
  end

  task automatic push_exp(input logic [15:0] es, input logic ec, input int ee);
    exp_t e;
    e.s = es;
    e.c = ec;
    e.e = ee;
    q.push_back(e);
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                      input logic mv, input logic [15:0] es, input logic ec, input int ee);
    int n;
    push_exp(es, ec, ee);
    a = av;
    b = bv;
    cin = cv;
    approx_en = mv;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_left", 32'(q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
`ifdef APPROX_ADDER_ERR_EN
    check("rst_err_cnt", 32'(err_cnt), 32'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    // Basic approx case and two-cycle latency
    send(16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0, -1);
    @(negedge clk);
    check("latency_c1", 32'(out_valid), 32'(0));
    @(negedge clk);
    check("latency_c2", 32'(out_valid), 32'(1));
    drain();
`ifdef APPROX_ADDER_ERR_EN
    check("err_cnt_t1", 32'(err_cnt), 32'(1));
`endif

    send(16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b0, 8);
    drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, -1);
    drain();

    // Back-pressure: two fill the pipe, the third waits
    out_ready = 1'b0;
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 0);
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 0);
    push_exp(16'h0033, 1'b0, 0);
    a = 16'h0011;
    b = 16'h0022;
    cin = 1'b0;
    approx_en = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_hold_sum", 32'(sum), 32'(16'h0300));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("bp_third_accept", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Mode toggled every transaction, back to back
    send(16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b0, 8);
    send(16'h0008, 16'h0008, 1'b0, 1'b0, 16'h0010, 1'b0, 0);
    send(16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0, -1);
    send(16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, -1);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0);
    send(16'h1234, 16'h0003, 1'b1, 1'b1, 16'h1237, 1'b0, -1);
    send(16'h1234, 16'h0003, 1'b1, 1'b0, 16'h1238, 1'b0, 0);
    drain();

    // Reset with two transactions in flight
    out_ready = 1'b0;
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 0);
    send(16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0018, 1'b0, 8);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    q.delete();
`ifdef APPROX_ADDER_ERR_EN
    check("mid_rst_err_cnt", 32'(err_cnt), 32'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_mid_rst", 32'(in_ready), 32'(1));
    repeat (5) begin
      @(negedge clk);
      check("no_stale_out", 32'(out_valid), 32'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_adder_pipe.md
Name: approx_adder_pipe

Overview:
- Parametrised, pipelined N-bit adder with a runtime-selectable approximate lower part of the Lower-part-OR Adder (LOA) type.
- Successor to the single-bit approximate full adder cell: generalised in width, approximate-bit count and pipeline depth.
- Adds valid/ready handshaking and a per-transaction exact/approximate mode.
- Sits between operand producers and the accuracy-evaluation datapath.

Parameters:
- WIDTH, 16, operand and sum width; must be divisible by STAGES.
- APPROX_BITS, 4, LSBs computed approximately when in approx mode; range 0..WIDTH-1. 0 means always exact.
- STAGES, 2, pipeline depth; legal values 1, 2, 4. Each stage resolves WIDTH/STAGES bits of the carry chain.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- approx_en  input  1  1 = approximate mode for this transaction, 0 = exact.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, out_valid=0, sum=0, cout=0. in_ready=1 from the first cycle after reset release. Reset mid-operation discards all in-flight transactions; no partial result is ever presented.
- Transfer rules:
  - Input transfer when in_valid&in_ready.
  - Output transfer when out_valid&out_ready.
  - a, b, cin and approx_en are captured at input transfer and travel with the transaction; later changes to approx_en do not affect it.
- Approx mode, bit positions i < APPROX_BITS:
  - sum[i] = a[i]|b[i]; bit 0 additionally ORs in cin.
  - Carry into bit APPROX_BITS = a[APPROX_BITS-1]&b[APPROX_BITS-1].
  - Bits >= APPROX_BITS are an exact ripple sum using that carry.
- Exact mode: {cout,sum} = a+b+cin, full WIDTH+1-bit result.
- Pipeline:
  - Stage k computes bits [k*W/S +: W/S] from the registered carry of stage k-1.
  - Upper operand bits and already-computed lower sum bits are carried forward in stage registers.
  - Latency is STAGES cycles from input transfer to out_valid with no back-pressure.
  - Throughput is 1 transaction per cycle.
- Stall: each stage advances when it is empty or the next stage advances. in_ready = ~stage0_valid | stage0_advances (combinational from out_ready through the chain). Without back-pressure the pipeline holds exactly STAGES transactions.
- While out_valid=1 and out_ready=0: sum, cout and out_valid hold stable.
- Simultaneous input and output transfer on a full pipeline is legal and loses no data.
- Ordering is strictly FIFO.

Optional Feature:
- Macro: APPROX_ADDER_ERR_EN.
- When defined:
  - The exact sum is computed in parallel for every transaction.
  - Extra output err  output  WIDTH+2  signed two's-complement error = {cout,sum}_approx - {cout,sum}_exact, valid with out_valid and held while stalled. err is 0 for exact-mode transactions.
  - Extra output err_cnt  output  16  saturating count of output transfers with err!=0; reset to 0; stays at 0xFFFF once reached.
- When not defined: neither port exists and no exact-reference logic is synthesised.

Test Plan:
- Defaults, approx_en=1, a=0x000F, b=0x0001, cin=0 -> after 2 cycles sum=0x000F, cout=0; with ERR_EN err=-1, err_cnt=1.
- approx_en=1, a=0x0008, b=0x0008 -> sum=0x0018, cout=0 (exact result is 0x0010); err=+8.
- approx_en=0, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0. Repeat with approx_en=1 -> sum=0xFFFF, cout=0.
- out_ready=0, three back-to-back valid inputs -> two accepted, in_ready=0 on the third. Release out_ready -> results emerge in order, one per cycle, the third is accepted, none lost or duplicated.
- Toggle approx_en every cycle across 8 consecutive inputs -> each result matches the mode captured at its own input transfer.
- Assert rst while 2 transactions are in flight -> out_valid=0 immediately; in_ready=1 in the first cycle after release; err_cnt=0; no stale result appears afterwards.
